// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sample/twiddle widths, the complex sample
// record and the rounding constant used after Q1.(TW-1) multiplies.
package fft_pkg;

   localparam int DW_DEF = 16;
   localparam int TW_DEF = 16;

   // One complex sample at the default data width.
   typedef struct packed {
      logic signed [DW_DEF-1:0] re;
      logic signed [DW_DEF-1:0] im;
   } cplx_t;

   // Half an LSB of a Q1.(tw-1) product: added before the right shift by tw-1.
   function automatic logic signed [63:0] round_const(input int tw);
      round_const = 64'sd1 <<< (tw - 2);
   endfunction

endpackage

// File: rtl/cmul_round.sv
// Registered complex multiply P = W * B with round-half-up to DW+1 bits.
// W is signed Q1.(TW-1); -1.0 (most negative code) is handled exactly.
module cmul_round
   import fft_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int TW = TW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_i,
   input  logic [DW-1:0] br_i,
   input  logic [DW-1:0] bi_i,
   input  logic [TW-1:0] wr_i,
   input  logic [TW-1:0] wi_i,
   output logic [DW:0]   pr_o,
   output logic [DW:0]   pi_o
);

   localparam int MW = DW + TW;
   localparam int PW = DW + TW + 1;
   localparam logic signed [PW-1:0] RND = PW'(round_const(TW));

   logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
   logic signed [PW-1:0] rnd_r, rnd_i;
   logic [DW:0]          pr_d, pi_d, pr_q, pi_q;

   // Full-precision products and sums, then round and keep DW+1 bits.
   always_comb begin
      m_rr  = MW'($signed(br_i)) * MW'($signed(wr_i));
      m_ii  = MW'($signed(bi_i)) * MW'($signed(wi_i));
      m_ri  = MW'($signed(br_i)) * MW'($signed(wi_i));
      m_ir  = MW'($signed(bi_i)) * MW'($signed(wr_i));
      rnd_r = ({m_rr[MW-1], m_rr} - {m_ii[MW-1], m_ii}) + RND;
      rnd_i = ({m_ri[MW-1], m_ri} + {m_ir[MW-1], m_ir}) + RND;
      pr_d  = (DW+1)'(rnd_r >>> (TW - 1));
      pi_d  = (DW+1)'(rnd_i >>> (TW - 1));
   end

   // Product register; holds while the pipeline is stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pr_q <= '0;
         pi_q <= '0;
      end else if (en_i) begin
         pr_q <= pr_d;
         pi_q <= pi_d;
      end
   end

   assign pr_o = pr_q;
   assign pi_o = pi_q;

endmodule

// File: rtl/butterfly2_pipe.sv
// Radix-2 butterfly, 3-stage pipeline: X = A + W*B, Y = A - W*B.
// S1 registers operands, S2 (cmul_round) forms the rounded product,
// S3 adds/subtracts, optionally halves (SCALE=1) and limits to DW bits.
// Define BUTTERFLY2_SAT_EN to clamp outputs and report sat; otherwise the
// outputs wrap and sat stays 0.
// All stages advance together when the output is empty or being taken.
module butterfly2_pipe
   import fft_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int TW    = TW_DEF,
   parameter int SCALE = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] ar,
   input  logic [DW-1:0] ai,
   input  logic [DW-1:0] br,
   input  logic [DW-1:0] bi,
   input  logic [TW-1:0] wr,
   input  logic [TW-1:0] wi,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] xr,
   output logic [DW-1:0] xi,
   output logic [DW-1:0] yr,
   output logic [DW-1:0] yi,
   output logic          sat
);

   localparam logic signed [DW+1:0] MAXV = {3'b000, {(DW-1){1'b1}}};
   localparam logic signed [DW+1:0] MINV = {3'b111, {(DW-1){1'b0}}};
   localparam logic [DW-1:0]        MAXO = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0]        MINO = {1'b1, {(DW-1){1'b0}}};

   logic          en;
   logic          v1_q, v2_q, ov_q;
   logic [DW-1:0] ar1_q, ai1_q, br1_q, bi1_q, ar2_q, ai2_q;
   logic [TW-1:0] wr1_q, wi1_q;
   logic [DW:0]   pr2, pi2;
   logic signed [DW+1:0] sxr, sxi, syr, syi;
   logic [DW:0]   fxr, fxi, fyr, fyi;
   logic [DW-1:0] xr_d, xi_d, yr_d, yi_d, xr_q, xi_q, yr_q, yi_q;
   logic          sat_d, sat_q;

   // Scale and limit one DW+2-bit sum; MSB of the result flags a clamp.
   function automatic logic [DW:0] finish(input logic signed [DW+1:0] s);
      logic signed [DW+1:0] t;
      t = (SCALE != 0) ? (s >>> 1) : s;
`ifdef BUTTERFLY2_SAT_EN
      if (t > MAXV)
         finish = {1'b1, MAXO};
      else if (t < MINV)
         finish = {1'b1, MINO};
      else
         finish = {1'b0, t[DW-1:0]};
`else
      finish = {1'b0, t[DW-1:0]};
`endif
   endfunction

   assign en       = !ov_q || out_ready;
   assign in_ready = en;

   // S1: capture operands (bubbles included) whenever the pipe moves.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q  <= 1'b0;
         ar1_q <= '0;
         ai1_q <= '0;
         br1_q <= '0;
         bi1_q <= '0;
         wr1_q <= '0;
         wi1_q <= '0;
      end else if (en) begin
         v1_q  <= in_valid;
         ar1_q <= ar;
         ai1_q <= ai;
         br1_q <= br;
         bi1_q <= bi;
         wr1_q <= wr;
         wi1_q <= wi;
      end
   end

   cmul_round #(
      .DW(DW),
      .TW(TW)
   ) u_cmul (
      .clk (clk),
      .rst (rst),
      .en_i(en),
      .br_i(br1_q),
      .bi_i(bi1_q),
      .wr_i(wr1_q),
      .wi_i(wi1_q),
      .pr_o(pr2),
      .pi_o(pi2)
   );

   // S2: carry valid and A alongside the product register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v2_q  <= 1'b0;
         ar2_q <= '0;
         ai2_q <= '0;
      end else if (en) begin
         v2_q  <= v1_q;
         ar2_q <= ar1_q;
         ai2_q <= ai1_q;
      end
   end

   // S3 combinational: A +/- P in DW+2 bits, then scale and limit.
   always_comb begin
      sxr   = {{2{ar2_q[DW-1]}}, ar2_q} + {pr2[DW], pr2};
      sxi   = {{2{ai2_q[DW-1]}}, ai2_q} + {pi2[DW], pi2};
      syr   = {{2{ar2_q[DW-1]}}, ar2_q} - {pr2[DW], pr2};
      syi   = {{2{ai2_q[DW-1]}}, ai2_q} - {pi2[DW], pi2};
      fxr   = finish(sxr);
      fxi   = finish(sxi);
      fyr   = finish(syr);
      fyi   = finish(syi);
      xr_d  = fxr[DW-1:0];
      xi_d  = fxi[DW-1:0];
      yr_d  = fyr[DW-1:0];
      yi_d  = fyi[DW-1:0];
      sat_d = fxr[DW] | fxi[DW] | fyr[DW] | fyi[DW];
   end

   // S3 output register: held stable until downstream takes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ov_q  <= 1'b0;
         xr_q  <= '0;
         xi_q  <= '0;
         yr_q  <= '0;
         yi_q  <= '0;
         sat_q <= 1'b0;
      end else if (en) begin
         ov_q  <= v2_q;
         xr_q  <= xr_d;
         xi_q  <= xi_d;
         yr_q  <= yr_d;
         yi_q  <= yi_d;
         sat_q <= sat_d;
      end
   end

   assign out_valid = ov_q;
   assign xr        = xr_q;
   assign xi        = xi_q;
   assign yr        = yr_q;
   assign yi        = yi_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_butterfly2_pipe.sv
// Directed bench for butterfly2_pipe: an unscaled and a scaled instance share
// stimulus; expected values are hand-computed for DW=TW=16.
module tb_butterfly2_pipe;
   import fft_pkg::*;

`ifdef BUTTERFLY2_SAT_EN
   localparam bit SATB = 1'b1;
`else
   localparam bit SATB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready;
   logic [15:0] ar, ai, br, bi, wr, wi;
   logic        in_ready0, out_valid0, sat0;
   logic        in_ready1, out_valid1, sat1;
   logic [15:0] xr0, xi0, yr0, yi0, xr1, xi1, yr1, yi1;

   always #5 clk = ~clk;

   butterfly2_pipe #(.DW(16), .TW(16), .SCALE(0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .ar(ar), .ai(ai), .br(br), .bi(bi), .wr(wr), .wi(wi),
      .out_valid(out_valid0), .out_ready(out_ready),
      .xr(xr0), .xi(xi0), .yr(yr0), .yi(yi0), .sat(sat0)
   );

   butterfly2_pipe #(.DW(16), .TW(16), .SCALE(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .ar(ar), .ai(ai), .br(br), .bi(bi), .wr(wr), .wi(wi),
      .out_valid(out_valid1), .out_ready(out_ready),
      .xr(xr1), .xi(xi1), .yr(yr1), .yi(yi1), .sat(sat1)
   );

   typedef struct {
      cplx_t a, b, w;
      int x0r, x0i, y0r, y0i, s0;
      int x1r, x1i, y1r, y1i;
   } vec_t;

   vec_t vt[8];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int a_r, a_i, b_r, b_i, w_r, w_i,
                               x0r, x0i, y0r, y0i, s0, x1r, x1i, y1r, y1i);
      vec_t v;
      v.a.re = 16'(a_r); v.a.im = 16'(a_i);
      v.b.re = 16'(b_r); v.b.im = 16'(b_i);
      v.w.re = 16'(w_r); v.w.im = 16'(w_i);
      v.x0r = x0r; v.x0i = x0i; v.y0r = y0r; v.y0i = y0i; v.s0 = s0;
      v.x1r = x1r; v.x1i = x1i; v.y1r = y1r; v.y1i = y1i;
      return v;
   endfunction

   task automatic drive(input cplx_t a, input cplx_t b, input cplx_t w);
      ar = a.re; ai = a.im; br = b.re; bi = b.im; wr = w.re; wi = w.im;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int    idx, got;
      cplx_t sa, zero;
      cplx_t sexp[8];

      //          A             B             W               X0/Y0 (unscaled)                               sat    X1/Y1 (scaled)
      vt[0] = mk(1000, 0,      2000, 0,      32767, 0,       3000, 0, -1000, 0,                              0,     1500, 0, -500, 0);
      vt[1] = mk(1000, 0,      2000, 0,      0, -32768,      1000, -2000, 1000, 2000,                        0,     500, -1000, 500, 1000);
      vt[2] = mk(30000, 0,     30000, 0,     32767, 0,       SATB ? 32767 : -5537, 0, 1, 0,                  SATB,  29999, 0, 0, 0);
      vt[3] = mk(100, -200,    300, 400,     -32768, 0,      -200, -600, 400, 200,                           0,     -100, -300, 200, 100);
      vt[4] = mk(0, 0,         1, 0,         16384, 0,       1, 0, -1, 0,                                    0,     0, 0, -1, 0);
      vt[5] = mk(5, 7,         -1, 0,        16384, 0,       5, 7, 5, 7,                                     0,     2, 3, 2, 3);
      vt[6] = mk(-30000, -30000, 30000, 30000, -32768, 0,    SATB ? -32768 : 5536, SATB ? -32768 : 5536, 0, 0, SATB, -30000, -30000, 0, 0);
      vt[7] = mk(10, 20,       1000, -2000,  16384, 16384,   1510, -480, -1490, 520,                         0,     755, -240, -745, 260);

      zero = '0;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive(zero, zero, zero);

      // Reset state before any clock edge.
      #1;
      chk("rst_out_valid0", int'(out_valid0), 0);
      chk("rst_out_valid1", int'(out_valid1), 0);
      chk("rst_xr0", int'(xr0), 0);
      chk("rst_sat0", int'(sat0), 0);

      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post_rst_in_ready", int'(in_ready0), 1);

      // Single-transaction vectors: latency and arithmetic.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(vt[i].a, vt[i].b, vt[i].w);
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_early_valid", i), int'(out_valid0), 0);
         @(negedge clk);
         chk($sformatf("v%0d_valid0", i), int'(out_valid0), 1);
         chk($sformatf("v%0d_valid1", i), int'(out_valid1), 1);
         chk($sformatf("v%0d_xr0", i), int'($signed(xr0)), vt[i].x0r);
         chk($sformatf("v%0d_xi0", i), int'($signed(xi0)), vt[i].x0i);
         chk($sformatf("v%0d_yr0", i), int'($signed(yr0)), vt[i].y0r);
         chk($sformatf("v%0d_yi0", i), int'($signed(yi0)), vt[i].y0i);
         chk($sformatf("v%0d_sat0", i), int'(sat0), vt[i].s0);
         chk($sformatf("v%0d_xr1", i), int'($signed(xr1)), vt[i].x1r);
         chk($sformatf("v%0d_xi1", i), int'($signed(xi1)), vt[i].x1i);
         chk($sformatf("v%0d_yr1", i), int'($signed(yr1)), vt[i].y1r);
         chk($sformatf("v%0d_yi1", i), int'($signed(yi1)), vt[i].y1i);
         chk($sformatf("v%0d_sat1", i), int'(sat1), 0);
      end

      // Back-pressure: 8 sets streamed, out_ready low in cycles 4..8.
      for (int k = 0; k < 8; k++) begin
         sexp[k].re = 16'((k + 1) * 100);
         sexp[k].im = 16'(-(k + 1) * 3);
      end
      idx = 0;
      got = 0;
      for (int cyc = 1; cyc <= 40 && got < 8; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 4 && cyc <= 8);
         #1;
         chk($sformatf("stall_in_ready_c%0d", cyc), int'(in_ready0), (cyc >= 4 && cyc <= 8) ? 0 : 1);
         if (out_valid0 && out_ready) begin
            chk($sformatf("stall_xr_%0d", got), int'($signed(xr0)), int'(sexp[got].re));
            chk($sformatf("stall_xi_%0d", got), int'($signed(xi0)), int'(sexp[got].im));
            chk($sformatf("stall_yr_%0d", got), int'($signed(yr0)), int'(sexp[got].re));
            got++;
         end
         if (idx < 8) begin
            drive(sexp[idx], zero, zero);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (in_valid && in_ready0) idx++;
      end
      chk("stall_delivered", got, 8);

      // Asynchronous reset with one result presented and two in flight.
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         sa.re = 16'(1234 + k);
         sa.im = 16'(5678);
         drive(sa, zero, zero);
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("arst_pre_valid", int'(out_valid0), 1);
      chk("arst_pre_xr", int'($signed(xr0)), 1234);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out_valid", int'(out_valid0), 0);
      chk("arst_xr", int'(xr0), 0);
      chk("arst_xi", int'(xi0), 0);
      chk("arst_yr", int'(yr0), 0);
      chk("arst_yi", int'(yi0), 0);
      chk("arst_sat", int'(sat0), 0);
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("arst_in_ready", int'(in_ready0), 1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("arst_no_stale_%0d", c), int'(out_valid0), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/butterfly2_pipe.md
BUTTERFLY2_PIPE -- requirements
Module: butterfly2_pipe

Interface
REQ-001 SHALL have parameter DW, default 16, meaning data width of each real/imag sample, two's complement.
REQ-002 SHALL have parameter TW, default 16, meaning twiddle width, signed Q1.(TW-1).
REQ-003 SHALL have parameter SCALE, default 0, meaning 1 = outputs divided by 2 per stage, 0 = unscaled.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  input operand set valid.
REQ-007 SHALL have port in_ready  out  1  block accepts operands this cycle.
REQ-008 SHALL have ports ar, ai, br, bi  in  DW each  operands A and B, real/imag.
REQ-009 SHALL have ports wr, wi  in  TW each  twiddle W, real/imag.
REQ-010 SHALL have port out_valid  out  1  result valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts result.
REQ-012 SHALL have ports xr, xi, yr, yi  out  DW each  X = A + W*B, Y = A - W*B.
REQ-013 SHALL have port sat  out  1  saturation occurred on the result currently presented.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 registers operands; S2 complex product P = W*B; S3 sum/difference, scaling, clamp.
REQ-015 SHALL have a latency of exactly 3 clk cycles from accepted input (in_valid && in_ready) to out_valid, when not stalled.
REQ-016 SHALL advance all stages together on enable en = !out_valid || out_ready; in_ready SHALL equal en, combinationally.
REQ-017 SHALL hold every stage, including outputs, while en = 0; no transfer lost, duplicated or reordered.
REQ-018 SHALL propagate bubbles when in_valid = 0; bubbles are not collapsed.
REQ-019 SHALL compute each P component as a full-precision (DW+TW+1)-bit sum of products, then round: add 2^(TW-2), arithmetic shift right TW-1, keep DW+1 bits.
REQ-020 SHALL form A +/- P in DW+2 bits, with no intermediate wrap.
REQ-021 SHALL, when SCALE=1, arithmetically shift the sum right 1 (floor) before clamping.
REQ-022 SHALL accept wr = -2^(TW-1) as exactly -1.0; +1.0 is not representable and SHALL be supplied as 2^(TW-1)-1.
REQ-023 SHALL keep results stable and out_valid high until out_ready is sampled high.

Reset
REQ-024 SHALL, on rst low, asynchronously clear out_valid, all stage valid bits, xr, xi, yr, yi and sat to 0, discarding in-flight data.
REQ-025 SHALL, after rst deasserts, drive in_ready = 1 on the first clk edge; no output until 3 cycles after the first accept.

Configuration
REQ-026 SHALL, with BUTTERFLY2_SAT_EN defined, clamp each output to [-2^(DW-1), 2^(DW-1)-1] and set sat when any of the four components clamped.
REQ-027 SHALL, without BUTTERFLY2_SAT_EN, wrap (truncate to DW LSBs) and tie sat to 0.

Structure
REQ-028 SHALL take DW/TW defaults, the rounding-constant function and the complex sample struct typedef from shared package fft_pkg.
REQ-029 SHALL instantiate one sub-module cmul_round (registered complex multiply with rounding), which implements stage S2.

Verification (DW=16, TW=16, out_ready=1 unless stated)
REQ-030 SHALL pass: SCALE=0, A=(1000,0), B=(2000,0), W=(32767,0) -> 3 cycles later X=(3000,0), Y=(-1000,0), sat=0.
REQ-031 SHALL pass: same A, B with W=(0,-32768) -> X=(1000,-2000), Y=(1000,2000).
REQ-032 SHALL pass: SCALE=1, the REQ-030 stimulus -> X=(1500,0), Y=(-500,0).
REQ-033 SHALL pass: A=(30000,0), B=(30000,0), W=(32767,0) -> with macro X=(32767,0), sat=1; without macro X=(-5537,0), sat=0; Y=(1,0) in both builds.
REQ-034 SHALL pass: in_valid held high, 8 distinct operand sets, out_ready low for cycles 4-8 -> in_ready low on exactly those cycles, all 8 results delivered in order, none lost.
REQ-035 SHALL pass: rst low with 2 transfers in flight -> out_valid, outputs and sat read 0 immediately without a clk edge; no stale result after release.
